// File: rtl/s_term_pkg.sv
// Shared mode encoding for the south-edge terminal tile.
// Each returned channel carries a 2-bit mode loaded from the frame config bus.
package s_term_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF  = 2'b00;
  localparam mode_t MODE_PASS = 2'b01;
  localparam mode_t MODE_REG1 = 2'b10;
  localparam mode_t MODE_REGN = 2'b11;

endpackage

// File: rtl/s_term_delay_line.sv
// One returned channel: a free-running PIPE_DEPTH-stage shift register
// with an output mux selecting off, pass-through, first-stage or last-stage tap.
module s_term_delay_line
  import s_term_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic  UserCLK,
  input  logic  reset,
  input  logic  flush,
  input  logic  d,
  input  mode_t mode,
  output logic  q
);

  logic [PIPE_DEPTH-1:0] r_stage;

  // A config write clears the line so no sample from the old mode leaks out.
  always_ff @(posedge UserCLK) begin
    if (reset || flush) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= d;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  always_comb begin
    q = 1'b0;
    unique case (mode)
      MODE_OFF:  q = 1'b0;
      MODE_PASS: q = d;
      MODE_REG1: q = r_stage[0];
      MODE_REGN: q = r_stage[PIPE_DEPTH-1];
      default:   q = 1'b0;
    endcase
  end

endmodule

// File: rtl/s_term_pipe.sv
// South-edge terminal tile: returns S_END as N_BEG per channel with a configurable delay,
// while passing the frame configuration bus straight through to the next tile.
module s_term_pipe
  import s_term_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int PIPE_DEPTH = 3,
  parameter int FRAME_BITS = 32,
  parameter int MAX_FRAMES = 20,
  parameter int CFG_FRAME  = 0
) (
  input  logic                  UserCLK,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     S_END,
  output logic [NUM_CH-1:0]     N_BEG,
  input  logic [FRAME_BITS-1:0] FrameData,
  output logic [FRAME_BITS-1:0] FrameData_O,
  input  logic [MAX_FRAMES-1:0] FrameStrobe,
  output logic [MAX_FRAMES-1:0] FrameStrobe_O,
  output logic                  CfgLoaded
);

  if (NUM_CH < 1 || 2 * NUM_CH > FRAME_BITS) begin : g_badNumCh
    $error("s_term_pipe: NUM_CH out of range");
  end
  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_badDepth
    $error("s_term_pipe: PIPE_DEPTH out of range");
  end
  if (CFG_FRAME < 0 || CFG_FRAME >= MAX_FRAMES) begin : g_badFrame
    $error("s_term_pipe: CFG_FRAME out of range");
  end

  logic                  w_cfgWrite;
  logic [2*NUM_CH-1:0]   r_mode;
  logic                  r_cfgLoaded;

  assign w_cfgWrite    = FrameStrobe[CFG_FRAME];
  assign FrameData_O   = FrameData;
  assign FrameStrobe_O = FrameStrobe;
  assign CfgLoaded     = r_cfgLoaded;

  // Level-sampled load: a strobe held for several cycles simply rewrites the same value.
  always_ff @(posedge UserCLK) begin
    if (reset) begin
      r_mode      <= '0;
      r_cfgLoaded <= 1'b0;
    end else if (w_cfgWrite) begin
      r_mode      <= FrameData[2*NUM_CH-1:0];
      r_cfgLoaded <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    s_term_delay_line #(
      .PIPE_DEPTH(PIPE_DEPTH)
    ) u_line (
      .UserCLK(UserCLK),
      .reset  (reset),
      .flush  (w_cfgWrite),
      .d      (S_END[i]),
      .mode   (r_mode[2*i +: 2]),
      .q      (N_BEG[i])
    );
  end

endmodule

// File: tb/tb_s_term_pipe.sv
// Scoreboard bench for s_term_pipe: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_s_term_pipe;

  logic        UserCLK;
  logic        reset;
  logic [15:0] S_END;
  logic [15:0] N_BEG;
  logic [31:0] FrameData;
  logic [31:0] FrameData_O;
  logic [19:0] FrameStrobe;
  logic [19:0] FrameStrobe_O;
  logic        CfgLoaded;

  typedef struct {
    int          step;
    logic [15:0] nBeg;
    logic        cfg;
    logic [31:0] fd;
    logic [19:0] fs;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   compared   = 0;
  int   mismatched = 0;
  int   stepNum    = 0;

  localparam logic [19:0] STB = 20'h00001;
  localparam logic [31:0] ALL_PASS = 32'h5555_5555;
  localparam logic [31:0] ALL_REG1 = 32'hAAAA_AAAA;
  localparam logic [31:0] ALL_REGN = 32'hFFFF_FFFF;
  localparam logic [31:0] MIXED    = 32'h0000_00E4;

  s_term_pipe #(
    .NUM_CH(16), .PIPE_DEPTH(3), .FRAME_BITS(32), .MAX_FRAMES(20), .CFG_FRAME(0)
  ) dut (
    .UserCLK      (UserCLK),
    .reset        (reset),
    .S_END        (S_END),
    .N_BEG        (N_BEG),
    .FrameData    (FrameData),
    .FrameData_O  (FrameData_O),
    .FrameStrobe  (FrameStrobe),
    .FrameStrobe_O(FrameStrobe_O),
    .CfgLoaded    (CfgLoaded)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic applyStimulus(input logic rst, input logic [19:0] st, input logic [31:0] fd,
                               input logic [15:0] s, input logic [15:0] expN, input logic expC,
                               input bit chk);
    exp_t e;
    @(posedge UserCLK);
    #1;
    reset       = rst;
    FrameStrobe = st;
    FrameData   = fd;
    S_END       = s;
    stepNum++;
    if (chk) begin
      e.step = stepNum;
      e.nBeg = expN;
      e.cfg  = expC;
      e.fd   = fd;
      e.fs   = st;
      sb.push_back(e);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compared++;
    if (N_BEG !== e.nBeg) begin
      mismatched++;
      $display("[TB] FAIL step %0d N_BEG: got %h want %h", e.step, N_BEG, e.nBeg);
    end
    compared++;
    if (CfgLoaded !== e.cfg) begin
      mismatched++;
      $display("[TB] FAIL step %0d CfgLoaded: got %b want %b", e.step, CfgLoaded, e.cfg);
    end
    compared++;
    if (FrameData_O !== e.fd) begin
      mismatched++;
      $display("[TB] FAIL step %0d FrameData_O: got %h want %h", e.step, FrameData_O, e.fd);
    end
    compared++;
    if (FrameStrobe_O !== e.fs) begin
      mismatched++;
      $display("[TB] FAIL step %0d FrameStrobe_O: got %h want %h", e.step, FrameStrobe_O, e.fs);
    end
  endtask

  always @(negedge UserCLK) begin
    if (sb.size() != 0) begin
      cur = sb.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; FrameStrobe = '0; FrameData = '0; S_END = '0;

    // Reset with noisy inputs, including a strobe on the reset edge.
    applyStimulus(1, 20'h00000, 32'h1234_5678, 16'hFFFF, 16'h0000, 0, 0);
    applyStimulus(1, STB,       ALL_PASS,      16'h1234, 16'h0000, 0, 1);
    applyStimulus(1, 20'hFFFFF, ALL_PASS,      16'hBEEF, 16'h0000, 0, 1);
    applyStimulus(0, 20'h00000, 32'hDEAD_BEEF, 16'hCAFE, 16'h0000, 0, 1);

    // All PASS.
    applyStimulus(0, STB,       ALL_PASS,      16'h0F0F, 16'h0000, 0, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h1234, 16'h1234, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'hFFFF, 16'hFFFF, 1, 1);
    applyStimulus(0, 20'h00002, 32'h0,         16'h0000, 16'h0000, 1, 1);

    // All REG1: one-cycle delay, flush on the write edge.
    applyStimulus(0, STB,       ALL_REG1,      16'h5A5A, 16'h5A5A, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'hA5A5, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'hA5A5, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h3C3C, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'h3C3C, 1, 1);

    // All REGN: walking one three cycles late, then a rewrite mid-stream.
    applyStimulus(0, STB,       ALL_REGN,      16'h1111, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0001, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0002, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0004, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0008, 16'h0001, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0010, 16'h0002, 1, 1);
    applyStimulus(0, STB,       ALL_REGN,      16'h0020, 16'h0004, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0040, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0080, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0100, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0200, 16'h0040, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'h0080, 1, 1);

    // Mixed OFF/PASS/REG1/REGN on channels 0-3, the rest OFF.
    applyStimulus(0, STB,       MIXED,         16'h000F, 16'h0100, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'hFF0F, 16'h0002, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'hFF0F, 16'h0006, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'hFF0F, 16'h0006, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'hFF0F, 16'h000E, 1, 1);

    // REGN data in flight, then a one-cycle reset discards it.
    applyStimulus(0, STB,       ALL_REGN,      16'hFFFF, 16'h000E, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'hFFFF, 16'h0000, 1, 1);
    applyStimulus(1, 20'h00000, 32'h0,         16'hFFFF, 16'h0000, 1, 1);
    applyStimulus(0, STB,       ALL_REGN,      16'h0000, 16'h0000, 0, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'h0000, 1, 1);
    applyStimulus(0, 20'h00000, 32'h0,         16'h0000, 16'h0000, 1, 1);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge UserCLK);
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
